// File: rtl/llc_set_table.sv
// Tracks the LLC sets in flight between the lookup/process stages and the update stage.
// Optional macro LLC_SET_TABLE_ERR_CHECK_EN adds a sticky error output for protocol misuse.

`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module llc_set_table #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PTR_W       = 3,
  parameter int unsigned SET_W       = `LLC_SET_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [SET_W-1:0] alloc_set,
  output logic             alloc_ready,
  output logic [PTR_W-1:0] alloc_pointer,
  input  logic             remove_set_from_table,
  input  logic [PTR_W-1:0] table_pointer_to_remove,
  input  logic [SET_W-1:0] check_set,
  output logic             check_conflict,
  input  logic             clr_all,
  output logic             table_full,
  output logic             table_empty,
  output logic [PTR_W:0]   occupancy
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
  ,
  output logic             err_sticky
`endif
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [SET_W-1:0]       set_q [NUM_ENTRIES];
  logic [PTR_W:0]         occ_q, occ_d;
  logic                   alloc_fire;
  logic                   remove_eff;

  assign table_full  = (occ_q == (PTR_W+1)'(NUM_ENTRIES));
  assign table_empty = (occ_q == '0);
  assign alloc_ready = !table_full;
  assign occupancy   = occ_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign remove_eff  = remove_set_from_table && valid_q[table_pointer_to_remove];

  // Lowest-numbered free entry; reads 0 when full.
  always_comb begin
    alloc_pointer = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_pointer = PTR_W'(i);
    end
  end

  always_comb begin
    check_conflict = 1'b0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (valid_q[i] && (set_q[i] == check_set)) check_conflict = 1'b1;
    end
  end

  // Alloc and remove never collide: alloc only ever targets a free entry.
  always_comb begin
    valid_d = valid_q;
    if (alloc_fire) valid_d[alloc_pointer] = 1'b1;
    if (remove_eff) valid_d[table_pointer_to_remove] = 1'b0;
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({alloc_fire, remove_eff})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) set_q[i] <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (alloc_fire) set_q[alloc_pointer] <= alloc_set;
    end
  end

`ifdef LLC_SET_TABLE_ERR_CHECK_EN
  logic [4:0] starve_q, starve_d;
  logic       starving;
  logic       err_d;

  assign starving = alloc_valid && !alloc_fire;

  // Counts prior consecutive starved cycles; saturates once the threshold is reached.
  always_comb begin
    starve_d = '0;
    if (starving) starve_d = (starve_q >= 5'd16) ? 5'd16 : starve_q + 5'd1;
  end

  always_comb begin
    err_d = err_sticky;
    if (remove_set_from_table && !valid_q[table_pointer_to_remove]) err_d = 1'b1;
    if (starving && (starve_q >= 5'd16)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q   <= '0;
      err_sticky <= 1'b0;
    end else if (clr_all) begin
      starve_q   <= '0;
      err_sticky <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      err_sticky <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_llc_set_table.sv
// Self-checking bench for llc_set_table: per-cycle model comparison plus directed literal checks.

`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module tb_llc_set_table;
  localparam int SW = `LLC_SET_BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [SW-1:0] alloc_set = '0;
  logic          alloc_ready;
  logic [2:0]    alloc_pointer;
  logic          remove_set_from_table = 1'b0;
  logic [2:0]    table_pointer_to_remove = '0;
  logic [SW-1:0] check_set = '0;
  logic          check_conflict;
  logic          clr_all = 1'b0;
  logic          table_full;
  logic          table_empty;
  logic [3:0]    occupancy;
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
  logic          err_sticky;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  llc_set_table dut (
    .clk                     (clk),
    .rst                     (rst),
    .alloc_valid             (alloc_valid),
    .alloc_set               (alloc_set),
    .alloc_ready             (alloc_ready),
    .alloc_pointer           (alloc_pointer),
    .remove_set_from_table   (remove_set_from_table),
    .table_pointer_to_remove (table_pointer_to_remove),
    .check_set               (check_set),
    .check_conflict          (check_conflict),
    .clr_all                 (clr_all),
    .table_full              (table_full),
    .table_empty             (table_empty),
    .occupancy               (occupancy)
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
    ,
    .err_sticky              (err_sticky)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a set of occupied slots, each holding the set it was given.
  bit            mv [8];
  logic [SW-1:0] ms [8];
  int            m_starve = 0;
  bit            m_err = 0;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < 8; i++) if (!mv[i]) return i;
    return 0;
  endfunction

  function automatic bit m_conflict(input logic [SW-1:0] s);
    for (int i = 0; i < 8; i++) if (mv[i] && ms[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int  cnt;
    int  fidx;
    bit  fire;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 8; i++) begin
          mv[i] = 1'b0;
          ms[i] = '0;
        end
        m_starve = 0;
        m_err    = 0;
      end
      cnt = m_count();
      check("m_occupancy", 32'(occupancy), cnt);
      check("m_full", 32'(table_full), 32'(cnt == 8));
      check("m_empty", 32'(table_empty), 32'(cnt == 0));
      check("m_ready", 32'(alloc_ready), 32'(cnt != 8));
      if (cnt != 8) check("m_pointer", 32'(alloc_pointer), m_free());
      check("m_conflict", 32'(check_conflict), 32'(m_conflict(check_set)));
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
      check("m_err", 32'(err_sticky), 32'(m_err));
`endif
      if (rst) begin
        if (clr_all) begin
          for (int i = 0; i < 8; i++) mv[i] = 1'b0;
          m_starve = 0;
          m_err    = 0;
        end else begin
          fire = alloc_valid && (cnt != 8);
          fidx = m_free();
          if (alloc_valid && !fire) m_starve++;
          else m_starve = 0;
          if (m_starve > 16) m_err = 1;
          if (remove_set_from_table && !mv[table_pointer_to_remove]) m_err = 1;
          if (remove_set_from_table) mv[table_pointer_to_remove] = 1'b0;
          if (fire) begin
            mv[fidx] = 1'b1;
            ms[fidx] = alloc_set;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_empty", 32'(table_empty), 1);
    check("rst_full", 32'(table_full), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_pointer", 32'(alloc_pointer), 0);
    check("rst_conflict", 32'(check_conflict), 0);
    step();
    rst = 1'b1;

    // Fill with 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_set   = SW'(8'h10 + i);
      #1;
      check("fill_pointer", 32'(alloc_pointer), i);
      step();
    end
    alloc_valid = 1'b0;
    #1;
    check("fill_full", 32'(table_full), 1);
    check("fill_ready", 32'(alloc_ready), 0);
    check("fill_occupancy", 32'(occupancy), 8);

    // Out-of-order retire of entry 3, refill with 0x55.
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd3;
    step();
    remove_set_from_table = 1'b0;
    #1;
    check("retire_pointer", 32'(alloc_pointer), 3);
    check("retire_occupancy", 32'(occupancy), 7);
    alloc_valid = 1'b1;
    alloc_set   = SW'(8'h55);
    step();
    alloc_valid = 1'b0;
    check_set   = SW'(8'h55);
    #1;
    check("refill_occupancy", 32'(occupancy), 8);
    check("refill_conflict55", 32'(check_conflict), 1);
    check_set = SW'(8'h13);
    #1;
    check("retired13_conflict", 32'(check_conflict), 0);

    // Full: remove in the same cycle does not open alloc; alloc lands a cycle later.
    alloc_valid = 1'b1;
    alloc_set   = SW'(8'h1A);
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd2;
    #1;
    check("full_rm_ready", 32'(alloc_ready), 0);
    step();
    remove_set_from_table = 1'b0;
    #1;
    check("after_rm_ready", 32'(alloc_ready), 1);
    check("after_rm_pointer", 32'(alloc_pointer), 2);
    step();
    alloc_valid = 1'b0;
    check_set   = SW'(8'h1A);
    #1;
    check("late_alloc_occupancy", 32'(occupancy), 8);
    check("conflict_1a", 32'(check_conflict), 1);
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd2;
    #1;
    check("conflict_during_rm", 32'(check_conflict), 1);
    step();
    remove_set_from_table = 1'b0;
    #1;
    check("conflict_after_rm", 32'(check_conflict), 0);

    // Drain 5,6,7 down to occupancy 4 (entries 0,1,3,4 valid).
    for (int p = 5; p < 8; p++) begin
      remove_set_from_table = 1'b1;
      table_pointer_to_remove = 3'(p);
      step();
    end
    remove_set_from_table = 1'b0;
    #1;
    check("drain_occupancy", 32'(occupancy), 4);

    // Simultaneous alloc 0x20 and remove 0.
    alloc_valid = 1'b1;
    alloc_set   = SW'(8'h20);
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd0;
    #1;
    check("simul_pointer", 32'(alloc_pointer), 2);
    step();
    alloc_valid = 1'b0;
    remove_set_from_table = 1'b0;
    check_set = SW'(8'h20);
    #1;
    check("simul_occupancy", 32'(occupancy), 4);
    check("simul_free0", 32'(alloc_pointer), 0);
    check("simul_conflict20", 32'(check_conflict), 1);
    check_set = SW'(8'h10);
    #1;
    check("simul_removed10", 32'(check_conflict), 0);

    // Invalid remove of 5, then clr_all with an alloc that must be dropped.
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd5;
    step();
    remove_set_from_table = 1'b0;
    #1;
    check("inv_rm_occupancy", 32'(occupancy), 4);
    check("inv_rm_pointer", 32'(alloc_pointer), 0);
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
    check("inv_rm_err", 32'(err_sticky), 1);
`endif
    clr_all     = 1'b1;
    alloc_valid = 1'b1;
    alloc_set   = SW'(8'h33);
    step();
    clr_all     = 1'b0;
    alloc_valid = 1'b0;
    check_set   = SW'(8'h33);
    #1;
    check("clr_occupancy", 32'(occupancy), 0);
    check("clr_empty", 32'(table_empty), 1);
    check("clr_dropped", 32'(check_conflict), 0);
`ifdef LLC_SET_TABLE_ERR_CHECK_EN
    check("clr_err", 32'(err_sticky), 0);
`endif

    // Async reset mid-fill at occupancy 5.
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_set   = SW'(8'h40 + i);
      step();
    end
    alloc_valid = 1'b0;
    #1;
    check("prerst_occupancy", 32'(occupancy), 5);
    #1;
    rst = 1'b0;
    #1;
    check("arst_empty", 32'(table_empty), 1);
    check("arst_occupancy", 32'(occupancy), 0);
    check("arst_ready", 32'(alloc_ready), 1);
    step();
    rst = 1'b1;
    alloc_valid = 1'b1;
    alloc_set   = SW'(8'h77);
    #1;
    check("post_rst_pointer", 32'(alloc_pointer), 0);
    step();
    alloc_valid = 1'b0;
    #1;
    check("post_rst_occupancy", 32'(occupancy), 1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
